mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-owner controller for the core's one data-memory port, shared between instruction fetch (IFU) and load/store (LSU).
- Arbitrates requests, then serialises one access at a time through an issue/wait state machine.
- Generates word-aligned address, byte mask and lane-replicated write data; aligns, then sign/zero-extends read data per MemOp.
- Sits between IFU/LSU and the pmem DPI wrapper.

Parameters:
STARVE_MAX, 3, consecutive LSU grants allowed while IFU is waiting before IFU is forced to win (range 1..15)

Ports:
clk  in  1  core clock; all state updates on posedge
rst_n  in  1  synchronous reset, active low
ifu_req_valid  in  1  IFU request (always 4-byte read)
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  32  fetch address
ifu_rsp_valid  out  1  one-cycle pulse, fetch data valid
ifu_rsp_data  out  32  fetched word
ifu_rsp_err  out  1  misaligned fetch, qualified by ifu_rsp_valid
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  32  byte address
lsu_wen  in  1  1 = store, 0 = load
lsu_memop  in  3  000 sb/lb, 001 sh/lh, 010 sw/lw, 100 lbu, 101 lhu
lsu_wdata  in  32  store data, right-justified
lsu_rsp_valid  out  1  one-cycle pulse, load data or store ack
lsu_rsp_data  out  32  extended load data; 0 for stores
lsu_rsp_err  out  1  misaligned address or illegal memop
mem_valid  out  1  one-cycle access strobe to memory
mem_addr  out  32  word address, {addr[31:2],2'b00}
mem_wen  out  1  write access
mem_wdata  out  32  lane-replicated write data
mem_wmask  out  4  byte-enable mask
mem_rsp_valid  in  1  memory done; mem_rdata valid (ack for writes)
mem_rdata  in  32  read word

Behaviour:
- Reset: rst_n sampled low at posedge forces state IDLE, starve_cnt=0 and every output to 0. An access in flight is abandoned with no response pulse. mem_rsp_valid arriving outside WAIT is ignored.
- State IDLE:
  - req_ready is combinational, asserted only to the winner.
  - Winner is LSU if both are valid, unless starve_cnt==STARVE_MAX, in which case IFU wins.
  - On accept, latch owner, addr, wen, memop and wdata.
- Legality check on accept:
  - IFU is illegal if addr[1:0]!=0.
  - LSU is illegal if: half op and addr[0]=1; word op and addr[1:0]!=0; memop in {011,110,111}; or wen=1 with memop 100/101.
  - Illegal: go to RESP with err=1. Legal: go to ISSUE.
- ISSUE: assert mem_valid for exactly one cycle with mem_addr, mem_wen, mem_wdata and mem_wmask, then go to WAIT.
- WAIT: hold until mem_rsp_valid. On that edge, register the formatted data into the owner's rsp_data and go to RESP.
- RESP: pulse owner rsp_valid (and rsp_err when set) for one cycle, then go to IDLE. The next request can be accepted in the following cycle.
- Latency: accept at cycle T, mem_valid at T+1. If mem_rsp_valid arrives at T+2, rsp_valid is at T+3. An illegal request gives rsp_valid at T+1 and never touches memory.
- Write formatting (o = addr[1:0]):
  - byte: wmask = 0001<<o, wdata = {4{wdata[7:0]}}.
  - half: wmask = 0011<<o, wdata = {2{wdata[15:0]}}.
  - word: wmask = 1111, wdata unchanged.
  - Reads drive wmask=0000.
- Read formatting:
  - Shift: s = mem_rdata >> (8*o).
  - 000: sign-extend s[7:0] from bit 7. 001: sign-extend s[15:0] from bit 15. 010: s unchanged.
  - 100: zero-extend s[7:0]. 101: zero-extend s[15:0].
  - IFU always uses 010.
- starve_cnt: increments (saturating) when LSU is granted while ifu_req_valid=1; cleared on any IFU grant.
- Requests presented outside IDLE see req_ready=0 and must be held by the requester. A requester must not drop valid before ready.

Decomposition:
- Package npc_mem_pkg holds:
  - MemOp constants MEMOP_B=3'b000, MEMOP_H=3'b001, MEMOP_W=3'b010, MEMOP_BU=3'b100, MEMOP_HU=3'b101;
  - the state enum {IDLE, ISSUE, WAIT, RESP};
  - owner encoding OWN_IFU=0, OWN_LSU=1.
- One combinational sub-module, mem_lane_fmt, does the mask/replicate/shift/extend logic and is reused by the future cache refill path. The FSM, arbitration and starvation counter stay in mem_arbiter.

Test Plan:
1. LSU lb at 0x80000003, mem_rdata=0x80AABBCC, mem_rsp_valid 1 cycle after mem_valid -> mem_addr=0x80000000, wmask=0000; lsu_rsp_data=0xFFFFFF80 at T+3.
2. LSU lh at 0x80000002, mem_rdata=0x8001_1234 -> 0xFFFF8001. lhu at the same address -> 0x00008001.
3. LSU sb at 0x80000001, wdata=0x000000A5 -> wmask=0010, mem_wdata=0xA5A5A5A5; ack gives lsu_rsp_valid with data 0.
4. LSU sw at 0x80000002 -> lsu_rsp_valid with err=1 at T+1, no mem_valid. Also: memop=111 -> err, and sb with memop 100 -> err.
5. IFU and LSU both held valid, STARVE_MAX=3 -> grant order LSU, LSU, LSU, IFU, then LSU again; starve_cnt returns to 0.
6. rst_n low for 1 cycle during WAIT, late mem_rsp_valid afterwards -> no rsp_valid on either port, outputs 0, next request served normally.

Source files
------------

// File: rtl/npc_mem_pkg.sv
// rtl/npc_mem_pkg.sv - shared MemOp codes, FSM states and owner encoding for the data-memory arbiter
// Contents:
//   MEMOP_*      load/store size and extension codes as carried on lsu_memop
//   state_t      arbiter sequencing states
//   OWN_*        which requester owns the access in flight
//   lsu_illegal  alignment / opcode legality of an LSU request
package npc_mem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  // Unsigned opcodes only exist for loads, so a store carrying one is illegal.
  function automatic logic lsu_illegal(logic [1:0] offset, logic wen, logic [2:0] memop);
    logic ill;
    case (memop)
      MEMOP_B:  ill = 1'b0;
      MEMOP_BU: ill = wen;
      MEMOP_H:  ill = offset[0];
      MEMOP_HU: ill = offset[0] | wen;
      MEMOP_W:  ill = (offset != 2'b00);
      default:  ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - byte-lane formatting between a byte address and a 32-bit memory word
// Ports:
//   offset    in   byte offset within the word (addr[1:0])
//   memop     in   MemOp code
//   wen       in   1 = store formatting, 0 = load
//   wdata_in  in   right-justified store data
//   rdata_in  in   raw memory word
//   wmask     out  byte-enable mask (0000 for loads)
//   wdata_out out  lane-replicated store data (0 for loads)
//   rdata_out out  shifted and sign/zero-extended load data
module mem_lane_fmt
  import npc_mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  memop,
  input  logic        wen,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [31:0] shifted;

  always_comb begin
    wmask     = 4'b0000;
    wdata_out = 32'h0;
    if (wen) begin
      // Replicating across all lanes lets the mask alone pick the target byte(s).
      case (memop[1:0])
        2'b00: begin
          wmask     = 4'b0001 << offset;
          wdata_out = {4{wdata_in[7:0]}};
        end
        2'b01: begin
          wmask     = 4'b0011 << offset;
          wdata_out = {2{wdata_in[15:0]}};
        end
        2'b10: begin
          wmask     = 4'b1111;
          wdata_out = wdata_in;
        end
        default: begin
          wmask     = 4'b0000;
          wdata_out = 32'h0;
        end
      endcase
    end
  end

  always_comb begin
    shifted = rdata_in >> {offset, 3'b000};
    case (memop)
      MEMOP_B:  rdata_out = {{24{shifted[7]}}, shifted[7:0]};
      MEMOP_H:  rdata_out = {{16{shifted[15]}}, shifted[15:0]};
      MEMOP_BU: rdata_out = {24'h0, shifted[7:0]};
      MEMOP_HU: rdata_out = {16'h0, shifted[15:0]};
      default:  rdata_out = shifted;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-owner IFU/LSU arbiter and sequencer for the data-memory port
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   ifu_req_* / ifu_addr               IFU fetch request (4-byte read)
//   ifu_rsp_valid/data/err             IFU response pulse
//   lsu_req_* / lsu_addr/wen/memop/wdata   LSU load/store request
//   lsu_rsp_valid/data/err             LSU response pulse
//   mem_valid/addr/wen/wdata/wmask     one-cycle access strobe to memory
//   mem_rsp_valid/rdata                memory completion and read word
module mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rsp_data,
  output logic        ifu_rsp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [2:0]  lsu_memop,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rsp_data,
  output logic        lsu_rsp_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt;
  logic        owner_q;
  logic [31:0] addr_q;
  logic        wen_q;
  logic [2:0]  memop_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rsp_data_q;

  logic        ifu_win, lsu_win, accept, acc_illegal, ifu_forced;
  logic [3:0]  fmt_wmask;
  logic [31:0] fmt_wdata, fmt_rdata;

  // IFU takes priority only once LSU has won STARVE_MAX times in a row over it.
  assign ifu_forced  = ifu_req_valid && (starve_cnt == 4'(STARVE_MAX));
  assign lsu_win     = lsu_req_valid && !ifu_forced;
  assign ifu_win     = ifu_req_valid && !lsu_win;
  assign accept      = (state_q == IDLE) && rst_n && (ifu_win || lsu_win);
  assign acc_illegal = lsu_win ? lsu_illegal(lsu_addr[1:0], lsu_wen, lsu_memop)
                               : (ifu_addr[1:0] != 2'b00);

  mem_lane_fmt u_fmt (
    .offset    (addr_q[1:0]),
    .memop     (memop_q),
    .wen       (wen_q),
    .wdata_in  (wdata_q),
    .rdata_in  (mem_rdata),
    .wmask     (fmt_wmask),
    .wdata_out (fmt_wdata),
    .rdata_out (fmt_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = 32'h0;
    ifu_rsp_err   = 1'b0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_data  = 32'h0;
    lsu_rsp_err   = 1'b0;
    mem_valid     = 1'b0;
    mem_addr      = 32'h0;
    mem_wen       = 1'b0;
    mem_wdata     = 32'h0;
    mem_wmask     = 4'b0000;
    case (state_q)
      IDLE: begin
        ifu_req_ready = rst_n && ifu_win;
        lsu_req_ready = rst_n && lsu_win;
        if (accept) state_d = acc_illegal ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_valid = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wen   = wen_q;
        mem_wdata = fmt_wdata;
        mem_wmask = fmt_wmask;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) state_d = RESP;
      end
      RESP: begin
        if (owner_q == OWN_LSU) begin
          lsu_rsp_valid = 1'b1;
          lsu_rsp_data  = rsp_data_q;
          lsu_rsp_err   = err_q;
        end else begin
          ifu_rsp_valid = 1'b1;
          ifu_rsp_data  = rsp_data_q;
          ifu_rsp_err   = err_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
      owner_q    <= OWN_IFU;
      addr_q     <= 32'h0;
      wen_q      <= 1'b0;
      memop_q    <= MEMOP_W;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
      rsp_data_q <= 32'h0;
    end else begin
      if (accept) begin
        err_q      <= acc_illegal;
        rsp_data_q <= 32'h0;
        if (lsu_win) begin
          owner_q <= OWN_LSU;
          addr_q  <= lsu_addr;
          wen_q   <= lsu_wen;
          memop_q <= lsu_memop;
          wdata_q <= lsu_wdata;
          if (ifu_req_valid && starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
        end else begin
          owner_q    <= OWN_IFU;
          addr_q     <= ifu_addr;
          wen_q      <= 1'b0;
          memop_q    <= MEMOP_W;
          wdata_q    <= 32'h0;
          starve_cnt <= 4'd0;
        end
      end
      // Stores return zero data; only loads capture the formatted word.
      if (state_q == WAIT && mem_rsp_valid) rsp_data_q <= wen_q ? 32'h0 : fmt_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import npc_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [2:0]  lsu_memop;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_rsp_data;
  logic        mem_valid, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_memop(lsu_memop), .lsu_wdata(lsu_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          cyc;
  } mtx_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rtx_t;

  mtx_t mq[$];
  rtx_t rq[$];
  int   gq[$];

  int          resp_delay = 1;
  logic [31:0] rd_val = 32'h0;

  // Memory model: answers each strobe after resp_delay cycles with rd_val.
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_valid === 1'b1) begin
        repeat (resp_delay) @(posedge clk);
        #1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rd_val;
        @(posedge clk);
        #1 mem_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: grants, memory strobes and responses against the scoreboard.
  always @(negedge clk) begin
    mtx_t m;
    rtx_t r;
    if (ifu_req_valid && ifu_req_ready) gq.push_back(0);
    if (lsu_req_valid && lsu_req_ready) gq.push_back(1);
    if (mem_valid === 1'b1) begin
      if (mq.size() == 0) chk("mem_unexpected", 32'd1, 32'd0);
      else begin
        m = mq.pop_front();
        chk("mem_addr",  mem_addr, m.addr);
        chk("mem_wen",   {31'h0, mem_wen}, {31'h0, m.wen});
        chk("mem_wdata", mem_wdata, m.wdata);
        chk("mem_wmask", {28'h0, mem_wmask}, {28'h0, m.wmask});
        chk("mem_cycle", cyc, m.cyc);
      end
    end
    if (ifu_rsp_valid === 1'b1 || lsu_rsp_valid === 1'b1) begin
      if (ifu_rsp_valid === 1'b1 && lsu_rsp_valid === 1'b1) chk("rsp_both", 32'd1, 32'd0);
      if (rq.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        r = rq.pop_front();
        chk("rsp_port", {31'h0, lsu_rsp_valid}, {31'h0, r.port});
        chk("rsp_err", {31'h0, lsu_rsp_valid ? lsu_rsp_err : ifu_rsp_err}, {31'h0, r.err});
        if (!r.err) chk("rsp_data", lsu_rsp_valid ? lsu_rsp_data : ifu_rsp_data, r.data);
        if (r.cyc >= 0) chk("rsp_cycle", cyc, r.cyc);
      end
    end
  end

  task automatic lsu_req(input logic [31:0] a, input logic w, input logic [2:0] op,
                         input logic [31:0] wd, input logic [3:0] emask, input logic [31:0] ewd,
                         input logic [31:0] edata, input logic eerr, input int lat,
                         input bit expect_rsp);
    int t = 0;
    bit got = 0;
    lsu_addr = a; lsu_wen = w; lsu_memop = op; lsu_wdata = wd; lsu_req_valid = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (lsu_req_ready) begin got = 1; t = cyc; end
    end
    if (!got) begin
      chk("lsu_accept_timeout", 32'd0, 32'd1);
      lsu_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 lsu_req_valid = 1'b0;
    if (!eerr) mq.push_back('{{a[31:2], 2'b00}, w, ewd, emask, t + 1});
    if (expect_rsp) rq.push_back('{OWN_LSU, edata, eerr, (lat > 0) ? t + lat : -1});
  endtask

  task automatic ifu_req(input logic [31:0] a, input logic [31:0] edata, input logic eerr,
                         input int lat);
    int t = 0;
    bit got = 0;
    ifu_addr = a; ifu_req_valid = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (ifu_req_ready) begin got = 1; t = cyc; end
    end
    if (!got) begin
      chk("ifu_accept_timeout", 32'd0, 32'd1);
      ifu_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ifu_req_valid = 1'b0;
    if (!eerr) mq.push_back('{{a[31:2], 2'b00}, 1'b0, 32'h0, 4'b0000, t + 1});
    rq.push_back('{OWN_IFU, edata, eerr, t + lat});
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (op)
      MEMOP_B:  return {{24{b[7]}}, b};
      MEMOP_BU: return {24'h0, b};
      MEMOP_H:  return {{16{h[15]}}, h};
      MEMOP_HU: return {16'h0, h};
      default:  return rd;
    endcase
  endfunction

  task automatic wait_idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  ops[5];
    logic [2:0]  op;
    logic [1:0]  off;
    ops[0] = MEMOP_B; ops[1] = MEMOP_H; ops[2] = MEMOP_W; ops[3] = MEMOP_BU; ops[4] = MEMOP_HU;

    rst_n = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_memop = 3'b0; lsu_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {26'h0, mem_valid, mem_wen, ifu_rsp_valid, lsu_rsp_valid,
                       ifu_req_ready, lsu_req_ready}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_wmask", {28'h0, mem_wmask}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Loads: sign/zero extension and lane shift
    rd_val = 32'h80AABBCC;
    lsu_req(32'h80000003, 1'b0, MEMOP_B, 32'h0, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1);
    wait_idle(3);
    rd_val = 32'h80011234;
    lsu_req(32'h80000002, 1'b0, MEMOP_H, 32'h0, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0, 3, 1);
    wait_idle(3);
    lsu_req(32'h80000002, 1'b0, MEMOP_HU, 32'h0, 4'b0000, 32'h0, 32'h00008001, 1'b0, 3, 1);
    wait_idle(3);

    // Stores: mask and lane replication, zero data on ack
    lsu_req(32'h80000001, 1'b1, MEMOP_B, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0, 3, 1);
    wait_idle(3);
    lsu_req(32'h80000006, 1'b1, MEMOP_H, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0, 3, 1);
    wait_idle(3);
    lsu_req(32'h80000008, 1'b1, MEMOP_W, 32'h12345678, 4'b1111, 32'h12345678, 32'h0, 1'b0, 3, 1);
    wait_idle(3);

    // Illegal requests: immediate error, no memory strobe
    lsu_req(32'h80000002, 1'b1, MEMOP_W, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1, 1);
    wait_idle(1);
    lsu_req(32'h80000000, 1'b0, 3'b111, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1, 1);
    wait_idle(1);
    lsu_req(32'h80000000, 1'b1, MEMOP_BU, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1, 1);
    wait_idle(1);
    lsu_req(32'h80000005, 1'b0, MEMOP_H, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1, 1);
    wait_idle(1);

    // IFU fetches
    rd_val = 32'hDEADBEEF;
    ifu_req(32'h80000010, 32'hDEADBEEF, 1'b0, 3);
    wait_idle(3);
    ifu_req(32'h80000012, 32'h0, 1'b1, 1);
    wait_idle(2);

    // Random legal loads with slower memory
    resp_delay = 2;
    for (int i = 0; i < 8; i++) begin
      op  = ops[$urandom_range(0, 4)];
      off = 2'($urandom_range(0, 3));
      if (op[1:0] == 2'b01) off[0] = 1'b0;
      if (op == MEMOP_W) off = 2'b00;
      rd_val = $urandom;
      lsu_req({28'h8000010, 2'b00, off}, 1'b0, op, 32'h0, 4'b0, 32'h0,
              ld_model(op, off, rd_val), 1'b0, 4, 1);
      wait_idle(4);
    end
    resp_delay = 1;

    // Starvation: both held valid -> L L L I L
    rd_val = 32'h13579BDF;
    gq.delete();
    fork
      begin
        for (int i = 0; i < 4; i++)
          lsu_req(32'h80000100 + 32'(4 * i), 1'b0, MEMOP_W, 32'h0, 4'b0, 32'h0,
                  32'h13579BDF, 1'b0, 3, 1);
      end
      ifu_req(32'h80000200, 32'h13579BDF, 1'b0, 3);
    join
    wait_idle(4);
    chk("grant_count", 32'(gq.size()), 32'd5);
    if (gq.size() == 5) begin
      chk("grant0", 32'(gq[0]), 32'd1);
      chk("grant1", 32'(gq[1]), 32'd1);
      chk("grant2", 32'(gq[2]), 32'd1);
      chk("grant3", 32'(gq[3]), 32'd0);
      chk("grant4", 32'(gq[4]), 32'd1);
    end
    chk("starve_cnt", {28'h0, dut.starve_cnt}, 32'd0);

    // Reset during WAIT abandons the access; the late memory response is ignored
    resp_delay = 4;
    lsu_req(32'h80000020, 1'b0, MEMOP_W, 32'h0, 4'b0, 32'h0, 32'h0, 1'b0, 3, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wait_ctrl", {28'h0, mem_valid, mem_wen, ifu_rsp_valid, lsu_rsp_valid}, 32'h0);
    chk("rst_wait_data", lsu_rsp_data | ifu_rsp_data | mem_addr | mem_wdata, 32'h0);
    wait_idle(6);
    resp_delay = 1;
    rd_val = 32'h0BADF00D;
    lsu_req(32'h80000024, 1'b0, MEMOP_W, 32'h0, 4'b0, 32'h0, 32'h0BADF00D, 1'b0, 3, 1);
    wait_idle(4);

    chk("mem_queue_empty", 32'(mq.size()), 32'd0);
    chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
